delay_line_reader: RTL and testbench

Serial-to-parallel read port for a recirculating delay-line store. It taps the serial bit stream leaving a tank and tracks the current bit and word position against a major-cycle sync pulse. On request, it waits for the addressed word to come round and shifts it in LSB first. It then presents the word in parallel with a one-cycle valid pulse. It sits between the tank's serial output and the order/arithmetic logic and never disturbs recirculation.

---
 rtl/delay_line_reader.sv | 182 ++++++++++++++++++
 tb/tb_delay_line_reader.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/delay_line_reader.sv
// rtl/delay_line_reader.sv - serial-to-parallel read port for a recirculating delay-line tank
module delay_line_reader #(
  parameter int WORD_WIDTH = 18,
  parameter int STORE_LEN  = 32,
  parameter int AW         = (STORE_LEN > 1) ? $clog2(STORE_LEN) : 1,
  parameter int BW         = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  data_in,
  input  logic                  sync,
  input  logic                  rd_req,
  input  logic [AW-1:0]         rd_addr,
  output logic                  busy,
  output logic                  rd_valid,
  output logic [WORD_WIDTH-1:0] rd_data,
  output logic                  rd_err,
  output logic [BW-1:0]         bit_pos,
  output logic [AW-1:0]         word_pos
);

  localparam logic [BW-1:0] LAST_BIT  = BW'(WORD_WIDTH - 1);
  localparam logic [AW-1:0] LAST_WORD = AW'(STORE_LEN - 1);
  // One extra bit so STORE_LEN itself is representable for the range check.
  localparam logic [AW:0]   LEN_EXT   = (AW + 1)'(STORE_LEN);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_SHIFT = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [BW-1:0]           bit_cnt;
  logic [AW-1:0]           word_cnt;
  logic [AW-1:0]           addr_q;
  logic [WORD_WIDTH-1:0]   cap_q;
  logic [WORD_WIDTH-1:0]   cap_nxt;
  logic [WORD_WIDTH-1:0]   rd_data_q;
  logic                    rd_valid_q;
  logic                    rd_err_q;

  logic [BW-1:0]           eff_bit;
  logic [AW-1:0]           eff_word;
  logic [BW-1:0]           nxt_bit;
  logic [AW-1:0]           nxt_word;
  logic                    addr_ok;
  logic                    accept;
  logic                    cap_en;
  logic                    done;
  logic                    err_d;

  // Effective position of the bit on data_in: sync forces (0,0), else the counters.
  always_comb begin
    eff_bit  = bit_cnt;
    eff_word = word_cnt;
    if (sync) begin
      eff_bit  = '0;
      eff_word = '0;
    end
  end

  // Advance the effective position by one bit period, wrapping bit then word.
  always_comb begin
    nxt_bit  = eff_bit + 1'b1;
    nxt_word = eff_word;
    if (eff_bit == LAST_BIT) begin
      nxt_bit  = '0;
      nxt_word = (eff_word == LAST_WORD) ? '0 : eff_word + 1'b1;
    end
  end

  // Capture vector with the current serial bit dropped into its effective slot.
  always_comb begin
    cap_nxt = cap_q;
    for (int i = 0; i < WORD_WIDTH; i++) begin
      if (eff_bit == BW'(i)) begin
        cap_nxt[i] = data_in;
      end
    end
  end

  assign addr_ok = ({1'b0, rd_addr} < LEN_EXT);

  // Read sequencer: next state plus per-cycle capture/complete/error strobes.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    cap_en  = 1'b0;
    done    = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rd_req) begin
          if (addr_ok) begin
            accept  = 1'b1;
            state_d = S_WAIT;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_WAIT: begin
        // Sync here only realigns; the comparison uses the realigned position.
        if (eff_word == addr_q && eff_bit == '0) begin
          cap_en = 1'b1;
          if (eff_bit == LAST_BIT) begin
            done    = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        // A sync that disagrees with our own count means the stream slipped mid-word.
        if (sync && (bit_cnt != '0 || word_cnt != '0)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cap_en = 1'b1;
          if (eff_bit == LAST_BIT) begin
            done    = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Free-running position counters tracking the tank stream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt  <= '0;
      word_cnt <= '0;
    end else begin
      bit_cnt  <= nxt_bit;
      word_cnt <= nxt_word;
    end
  end

  // Address latch, capture register, and registered read results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      cap_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      rd_valid_q <= done;
      rd_err_q   <= err_d;
      if (accept) begin
        addr_q <= rd_addr;
      end
      if (cap_en) begin
        cap_q <= cap_nxt;
      end
      if (done) begin
        rd_data_q <= cap_nxt;
      end
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign rd_valid = rd_valid_q;
  assign rd_err   = rd_err_q;
  assign rd_data  = rd_data_q;
  assign bit_pos  = eff_bit;
  assign word_pos = eff_word;

endmodule

// File: tb/tb_delay_line_reader.sv
// tb/tb_delay_line_reader.sv - directed self-checking bench for delay_line_reader
module tb_delay_line_reader;

  logic        clk;
  logic        rst_n;
  logic        data_in;
  logic        sync;
  logic        rd_req;
  logic        rd_req2;
  logic [4:0]  rd_addr;
  logic        busy, rd_valid, rd_err;
  logic [17:0] rd_data;
  logic [4:0]  bit_pos, word_pos;
  logic        busy_2, rd_valid_2, rd_err_2;
  logic [17:0] rd_data_2;
  logic [4:0]  bit_pos_2, word_pos_2;

  int tests;
  int fails;
  int gen_bit;
  int gen_word;
  int lat;
  logic [17:0] last_data;
  logic        seen;

  typedef struct {
    int          rw;
    int          rb;
    logic [4:0]  addr;
    int          lat;
    logic [17:0] data;
  } vec_t;

  vec_t vecs[6];

  delay_line_reader #(.WORD_WIDTH(18), .STORE_LEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .sync(sync),
    .rd_req(rd_req), .rd_addr(rd_addr), .busy(busy), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_err(rd_err), .bit_pos(bit_pos), .word_pos(word_pos)
  );

  delay_line_reader #(.WORD_WIDTH(18), .STORE_LEN(24)) dut2 (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .sync(sync),
    .rd_req(rd_req2), .rd_addr(rd_addr), .busy(busy_2), .rd_valid(rd_valid_2),
    .rd_data(rd_data_2), .rd_err(rd_err_2), .bit_pos(bit_pos_2), .word_pos(word_pos_2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Present the stream bit for the current generator position (optionally forcing a resync).
  task automatic drive(input logic req, input logic [4:0] addr, input logic fsync);
    logic [17:0] w;
    if (fsync) begin
      gen_bit  = 0;
      gen_word = 0;
    end
    w       = 18'h00100 + 18'(gen_word);
    data_in = w[gen_bit];
    sync    = (gen_bit == 0 && gen_word == 0) || fsync;
    rd_req  = req;
    rd_addr = addr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    rd_req  = 1'b0;
    rd_req2 = 1'b0;
    if (gen_bit == 17) begin
      gen_bit  = 0;
      gen_word = (gen_word == 31) ? 0 : gen_word + 1;
    end else begin
      gen_bit = gen_bit + 1;
    end
  endtask

  task automatic goto_pos(input int w, input int b);
    int n;
    n = 0;
    while (!(gen_word == w && gen_bit == b) && n < 1200) begin
      drive(1'b0, 5'd0, 1'b0);
      tick();
      n++;
    end
    if (n >= 1200) check("goto_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_valid(input int start, output int l);
    l = start;
    while (rd_valid !== 1'b1 && l < 700) begin
      drive(1'b0, 5'd0, 1'b0);
      tick();
      l++;
    end
  endtask

  initial begin
    tests = 0; fails = 0;
    gen_bit = 0; gen_word = 0;
    rst_n = 1'b0; data_in = 1'b0; sync = 1'b0; rd_req = 1'b0; rd_req2 = 1'b0; rd_addr = 5'd0;

    vecs[0] = '{4, 17, 5'd5, 19, 18'h00105};
    vecs[1] = '{0, 0, 5'd0, 594, 18'h00100};
    vecs[2] = '{30, 17, 5'd31, 19, 18'h0011F};
    vecs[3] = '{31, 17, 5'd0, 19, 18'h00100};
    vecs[4] = '{10, 3, 5'd10, 591, 18'h0010A};
    vecs[5] = '{2, 5, 5'd20, 337, 18'h00114};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_valid", rd_valid, 0);
    check("rst_err", rd_err, 0);
    check("rst_data", rd_data, 0);
    check("rst_bit_pos", bit_pos, 0);
    check("rst_word_pos", word_pos, 0);
    rst_n = 1'b1;

    // Table of reads: request at a stream position, measure latency and data
    for (int i = 0; i < 6; i++) begin
      goto_pos(vecs[i].rw, vecs[i].rb);
      drive(1'b1, vecs[i].addr, 1'b0);
      #1;
      check($sformatf("v%0d_bit_pos", i), bit_pos, vecs[i].rb);
      check($sformatf("v%0d_word_pos", i), word_pos, vecs[i].rw);
      tick();
      check($sformatf("v%0d_busy", i), busy, 1);
      wait_valid(1, lat);
      check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d_data", i), rd_data, vecs[i].data);
      check($sformatf("v%0d_busy_at_valid", i), busy, 0);
      drive(1'b0, 5'd0, 1'b0);
      tick();
      check($sformatf("v%0d_valid_pulse", i), rd_valid, 0);
    end

    // Back-to-back: read 7, ignored request while busy, then read 8 from the valid cycle
    goto_pos(6, 17);
    drive(1'b1, 5'd7, 1'b0);
    tick();
    drive(1'b1, 5'd9, 1'b0);
    tick();
    check("b2b_busy_req_ignored", busy, 1);
    check("b2b_busy_req_no_err", rd_err, 0);
    wait_valid(2, lat);
    check("b2b_first_latency", lat, 19);
    check("b2b_first_data", rd_data, 18'h00107);
    drive(1'b1, 5'd8, 1'b0);
    tick();
    check("b2b_second_accepted", busy, 1);
    wait_valid(1, lat);
    check("b2b_second_latency", lat, 594);
    check("b2b_second_data", rd_data, 18'h00108);
    last_data = 18'h00108;

    // Abort: sync injected at bit 9 of the addressed word
    goto_pos(2, 17);
    drive(1'b1, 5'd3, 1'b0);
    tick();
    goto_pos(3, 9);
    check("abort_in_shift", busy, 1);
    drive(1'b0, 5'd0, 1'b1);
    #1;
    check("abort_bit_pos", bit_pos, 0);
    check("abort_word_pos", word_pos, 0);
    tick();
    check("abort_err", rd_err, 1);
    check("abort_no_valid", rd_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_data_held", rd_data, last_data);
    drive(1'b0, 5'd0, 1'b0);
    #1;
    check("abort_realign_bit", bit_pos, 1);
    check("abort_realign_word", word_pos, 0);
    tick();
    check("abort_err_pulse", rd_err, 0);

    // Rejected address on the 24-word instance, then its last legal address
    drive(1'b0, 5'd30, 1'b0);
    rd_req2 = 1'b1;
    tick();
    check("rej_err", rd_err_2, 1);
    check("rej_busy", busy_2, 0);
    drive(1'b0, 5'd0, 1'b0);
    tick();
    check("rej_err_pulse", rd_err_2, 0);
    check("rej_busy_after", busy_2, 0);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (rd_valid_2 === 1'b1) seen = 1'b1;
      drive(1'b0, 5'd0, 1'b0);
      tick();
    end
    check("rej_no_valid", seen, 0);
    drive(1'b0, 5'd23, 1'b0);
    rd_req2 = 1'b1;
    tick();
    check("acc23_busy", busy_2, 1);
    check("acc23_no_err", rd_err_2, 0);

    // Reset dropped mid-SHIFT
    goto_pos(5, 17);
    drive(1'b1, 5'd6, 1'b0);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 5'd0, 1'b0);
      tick();
    end
    check("midrst_in_shift", busy, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_valid", rd_valid, 0);
    check("midrst_err", rd_err, 0);
    check("midrst_data", rd_data, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    sync  = 1'b0;
    #1;
    check("midrst_bit_cnt", bit_pos, 0);
    check("midrst_word_cnt", word_pos, 0);
    gen_bit = 0;
    gen_word = 0;
    goto_pos(0, 17);
    check("midrst_idle", busy, 0);
    drive(1'b1, 5'd1, 1'b0);
    tick();
    wait_valid(1, lat);
    check("postrst_latency", lat, 19);
    check("postrst_data", rd_data, 18'h00101);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
